// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: 32-entry operand/opcode store with single-cycle
// ALU results and an iterative restoring divider for DIV/MOD, gated by a ready handshake.
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef struct packed {
    opcode_t            opc;
    operand_t           op_a;
    operand_t           op_b;
    logic signed [63:0] result;
  } instruction_t;
endpackage

module instr_register_mc
  import instr_register_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  output logic         ready,
  input  opcode_t      opcode,
  input  operand_t     operand_a,
  input  operand_t     operand_b,
  input  address_t     write_pointer,
  input  address_t     read_pointer,
  output instruction_t instruction_word
);
  localparam int CW = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
  state_t state, state_nx;

  instruction_t   store [DEPTH];
  logic [CW-1:0]  step;
  logic [31:0]    quo, rem, dvs;
  logic           is_mod, neg_q, neg_r;
  address_t       dst;

  logic        capture, start_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic [63:0] q_ext, r_ext, fix_res;

  // DIV/MOD results are 0 at capture; the divider fills them in later when b != 0.
  function automatic logic signed [63:0] alu(opcode_t op, operand_t a, operand_t b);
    logic signed [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (op)
      PASSA:   alu = ea;
      PASSB:   alu = eb;
      ADD:     alu = ea + eb;
      SUB:     alu = ea - eb;
      MULT:    alu = ea * eb;
      default: alu = '0;
    endcase
  endfunction

  assign ready     = (state == S_IDLE);
  assign capture   = load_en && ready;
  assign start_div = capture && (opcode == DIV || opcode == MOD) && (operand_b != '0);
  assign a_mag     = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
  assign b_mag     = operand_b[31] ? (~operand_b + 32'd1) : operand_b;

  // Quotient bits shift in at the bottom of quo while dividend bits shift out the top.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_ext   = {32'b0, quo};
  assign r_ext   = {32'b0, rem};
  assign fix_res = is_mod ? (neg_r ? -r_ext : r_ext) : (neg_q ? -q_ext : q_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_div) state_nx = S_DIV;
      S_DIV:   if (step == CW'(DIV_STEPS - 1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      is_mod <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dst    <= '0;
    end else if (start_div) begin
      step   <= '0;
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      is_mod <= (opcode == MOD);
      neg_q  <= operand_a[31] ^ operand_b[31];
      neg_r  <= operand_a[31];
      dst    <= write_pointer;
    end else if (state == S_DIV) begin
      step <= step + 1'b1;
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (capture) begin
      store[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                                result: alu(opcode, operand_a, operand_b)};
    end else if (state == S_FIX) begin
      store[dst].result <= fix_res;
    end
  end

  assign instruction_word = store[read_pointer];
endmodule
